// File: rtl/uart_slip_decoder.sv
// SLIP (RFC 1055) decoder for a non-stallable UART byte strobe.
// Decoded bytes go through a first-word fall-through FIFO with per-frame last/err flags.
module uart_slip_decoder #(
  parameter int FIFO_DEPTH   = 16,
  parameter int CHECK_PARITY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_d,
  input  logic       rx_dv,
  input  logic       rx_parity_ok,
  output logic [7:0] m_d,
  output logic       m_dv,
  input  logic       m_dr,
  output logic       m_last,
  output logic       m_err,
  output logic       err_pulse
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_DATA = 2'd0, ST_ESC = 2'd1, ST_DROP = 2'd2} state_t;

  state_t        state, state_n;
  logic          p_valid, p_valid_n;
  logic [7:0]    p_byte, p_byte_n;
  logic          frame_err, frame_err_n;
  logic          flush_pend, flush_pend_n;
  logic          flush_err, flush_err_n;
  logic          err_n;
  logic          wr_en, rd_en, full;
  logic [9:0]    wr_word, head;
  logic          store_en, end_en, end_e;
  logic [7:0]    store_b;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_en  = m_dv & m_dr;
  assign head   = mem[rd_ptr];
  assign m_dv   = (count != '0);
  assign m_d    = head[7:0];
  assign m_last = m_dv & head[9];
  assign m_err  = m_dv & head[9] & head[8];

  // Byte decode: the pending byte P is only written once the next byte or END tells us whether it is last.
  always_comb begin
    state_n      = state;
    p_valid_n    = p_valid;
    p_byte_n     = p_byte;
    frame_err_n  = frame_err;
    flush_pend_n = flush_pend;
    flush_err_n  = flush_err;
    err_n        = 1'b0;
    wr_en        = 1'b0;
    wr_word      = 10'd0;
    store_en     = 1'b0;
    store_b      = 8'h00;
    end_en       = 1'b0;
    end_e        = 1'b0;

    if (flush_pend && !full) begin
      wr_en        = 1'b1;
      wr_word      = {1'b1, flush_err, p_byte};
      p_valid_n    = 1'b0;
      flush_pend_n = 1'b0;
    end else begin
      wr_en = 1'b0;
    end

    if (rx_dv) begin
      if (flush_pend && full) begin
        err_n       = 1'b1;
        frame_err_n = 1'b1;
        state_n     = ST_DROP;
      end else if ((CHECK_PARITY != 0) && !rx_parity_ok) begin
        err_n       = 1'b1;
        frame_err_n = 1'b1;
      end else begin
        case (state)
          ST_DATA: begin
            if (rx_d == 8'hC0) begin
              end_en = 1'b1;
              end_e  = frame_err;
            end else if (rx_d == 8'hDB) begin
              state_n = ST_ESC;
            end else begin
              store_en = 1'b1;
              store_b  = rx_d;
            end
          end
          ST_ESC: begin
            state_n = ST_DATA;
            case (rx_d)
              8'hDC: begin
                store_en = 1'b1;
                store_b  = 8'hC0;
              end
              8'hDD: begin
                store_en = 1'b1;
                store_b  = 8'hDB;
              end
              8'hC0: begin
                err_n  = 1'b1;
                end_en = 1'b1;
                end_e  = 1'b1;
              end
              default: begin
                err_n       = 1'b1;
                frame_err_n = 1'b1;
              end
            endcase
          end
          ST_DROP: begin
            if (rx_d == 8'hC0) begin
              state_n = ST_DATA;
              end_en  = 1'b1;
              end_e   = 1'b1;
            end else begin
              state_n = ST_DROP;
            end
          end
          default: state_n = ST_DATA;
        endcase
      end
    end else begin
      err_n = 1'b0;
    end

    // p_valid_n already reflects a flush issued this cycle, so at most one write happens.
    if (store_en) begin
      if (!p_valid_n) begin
        p_valid_n = 1'b1;
        p_byte_n  = store_b;
      end else if (!full) begin
        wr_en    = 1'b1;
        wr_word  = {2'b00, p_byte_n};
        p_byte_n = store_b;
      end else begin
        err_n       = 1'b1;
        frame_err_n = 1'b1;
        state_n     = ST_DROP;
      end
    end else begin
      store_b = store_b;
    end

    if (end_en) begin
      if (p_valid_n && !full) begin
        wr_en     = 1'b1;
        wr_word   = {1'b1, end_e, p_byte_n};
        p_valid_n = 1'b0;
      end else if (p_valid_n) begin
        flush_pend_n = 1'b1;
        flush_err_n  = end_e;
      end else begin
        p_valid_n = 1'b0;
      end
      frame_err_n = 1'b0;
    end else begin
      end_e = end_e;
    end
  end

  // Decoder state, error pulse and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_DATA;
      p_valid    <= 1'b0;
      p_byte     <= 8'h00;
      frame_err  <= 1'b0;
      flush_pend <= 1'b0;
      flush_err  <= 1'b0;
      err_pulse  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_n;
      p_valid    <= p_valid_n;
      p_byte     <= p_byte_n;
      frame_err  <= frame_err_n;
      flush_pend <= flush_pend_n;
      flush_err  <= flush_err_n;
      err_pulse  <= err_n;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

endmodule
